// File: rtl/mac_pkg.sv
// Shared defaults, control bundle and saturation constants for the MAC engine.
package mac_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } p_ctl_t;

    // Constants are built at 64 bits and truncated to ACC_W by the caller.
    function automatic logic [63:0] sat_max(int acc_w, bit is_signed);
        logic [63:0] r;
        r = '1;
        r = r >> (64 - acc_w + (is_signed ? 1 : 0));
        return r;
    endfunction

    function automatic logic [63:0] sat_min(int acc_w, bit is_signed);
        logic [63:0] r;
        r = '0;
        if (is_signed) begin
            r = '1;
            r = r << (acc_w - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered DATA_W x DATA_W multiplier with hold enable and sign select.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  accept,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  first,
    input  logic                  last,
    output p_ctl_t                p_ctl,
    output logic [2*DATA_W-1:0]   p_prod
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    logic [PW-1:0] prod;

    // A PW-bit product of extended operands is exact in both modes.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = {{DATA_W{a[DATA_W-1]}}, a};
            b_x = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            a_x = {{DATA_W{1'b0}}, a};
            b_x = {{DATA_W{1'b0}}, b};
        end
        prod = a_x * b_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ctl  <= '0;
            p_prod <= '0;
        end else if (en) begin
            p_ctl.valid <= accept;
            if (accept) begin
                p_prod      <= prod;
                p_ctl.first <= first;
                p_ctl.last  <= last;
            end
        end
    end

endmodule

// File: rtl/mac_accum_pipe.sv
// Handshaked multiply-accumulate engine: one result per first/last-delimited run.
module mac_accum_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1 - PW;

    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("mac_accum_pipe: ACC_W must be at least 2*DATA_W");
    end

    logic              en;
    logic              accept;
    p_ctl_t            p_ctl;
    logic [PW-1:0]     p_prod;

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_sticky;

    logic [ACC_W-1:0]  base;
    logic [ACC_W:0]    base_x;
    logic [ACC_W:0]    prod_x;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;
    logic              step;
    logic              load;

    // A pending result that is not being taken freezes the whole pipe.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign step     = en && p_ctl.valid;
    assign load     = step && p_ctl.last;

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .accept (accept),
        .a      (in_a),
        .b      (in_b),
        .first  (in_first),
        .last   (in_last),
        .p_ctl  (p_ctl),
        .p_prod (p_prod)
    );

    always_comb begin
        base = p_ctl.first ? '0 : acc;
        if (SIGNED != 0) begin
            base_x = {base[ACC_W-1], base};
            prod_x = {{XW{p_prod[PW-1]}}, p_prod};
        end else begin
            base_x = {1'b0, base};
            prod_x = {{XW{1'b0}}, p_prod};
        end
        sum = base_x + prod_x;
        if (SIGNED != 0) begin
            ovf = (base_x[ACC_W-1] == prod_x[ACC_W-1])
               && (sum[ACC_W-1] != base_x[ACC_W-1]);
        end else begin
            ovf = sum[ACC_W];
        end
        acc_next = sum[ACC_W-1:0];
        // Signed overflow direction follows the common operand sign.
        if (ovf && SATURATE != 0) begin
            if (SIGNED != 0 && base[ACC_W-1]) begin
                acc_next = ACC_MIN;
            end else begin
                acc_next = ACC_MAX;
            end
        end
        cnt_base = p_ctl.first ? '0 : cnt;
        cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_ONE;
        ovf_next = (!p_ctl.first && ovf_sticky) || ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_acc    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (step) begin
                acc        <= acc_next;
                cnt        <= cnt_next;
                ovf_sticky <= ovf_next;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_acc   <= acc_next;
                out_count <= cnt_next;
                out_ovf   <= ovf_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
